rel_fifo_egress: RTL and testbench

REL_FIFO_EGRESS -- requirements
Module: rel_fifo_egress

---
 rtl/rel_fifo_pkg.sv | 21 ++
 rtl/TMR_voter_fail.sv | 13 +
 rtl/bitwise_TMR_voter_fail.sv | 15 +
 rtl/rel_fifo_egress_tmr_part.sv | 102 ++++++++++
 rtl/rel_fifo_egress.sv | 178 +++++++++++++++++
 tb/tb_rel_fifo_egress.sv | 176 +++++++++++++++++
 6 files changed

// File: rtl/rel_fifo_pkg.sv
// Shared types for the rel_fifo family: egress buffer state encoding and helpers.
package rel_fifo_pkg;

  localparam int unsigned EgressDepth = 2;
  localparam int unsigned StateWidth  = 2;

  typedef enum logic [StateWidth-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } egress_state_e;

  // One-hot entry write enable for a pop landing at slot widx.
  function automatic logic [EgressDepth-1:0] egress_we(input logic pop, input logic widx);
    if (!pop) begin
      return 2'b00;
    end
    return widx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/TMR_voter_fail.sv
// Single-bit 2-of-3 majority voter with disagreement flag.
module TMR_voter_fail (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic majority_o,
  output logic fault_detected_o
);

  assign majority_o       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign fault_detected_o = (a_i ^ b_i) | (a_i ^ c_i);

endmodule

// File: rtl/bitwise_TMR_voter_fail.sv
// Per-bit 2-of-3 majority voter over a vector, flagging any bit disagreement.
module bitwise_TMR_voter_fail #(
  parameter int unsigned DataWidth = 1
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  output logic [DataWidth-1:0] majority_o,
  output logic                 fault_detected_o
);

  assign majority_o       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign fault_detected_o = |((a_i ^ b_i) | (a_i ^ c_i));

endmodule

// File: rtl/rel_fifo_egress_tmr_part.sv
// One replica of the egress buffer control: voted state/head feedback,
// next-state logic, pop strobe and entry write enables.
module rel_fifo_egress_tmr_part
  import rel_fifo_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   fifo_empty_i,
  input  logic                   ready_i,
  input  egress_state_e          state_a_i,
  input  egress_state_e          state_b_i,
  input  egress_state_e          state_c_i,
  input  logic                   head_a_i,
  input  logic                   head_b_i,
  input  logic                   head_c_i,
  output egress_state_e          state_o,
  output logic                   head_o,
  output logic [EgressDepth-1:0] we_o,
  output logic                   fifo_pop_o,
  output logic                   valid_o,
  output logic                   fault_o
);

  logic [StateWidth-1:0] state_vote;
  egress_state_e         state_v;
  egress_state_e         state_d;
  egress_state_e         state_q;
  logic                  head_v;
  logic                  head_d;
  logic                  head_q;
  logic                  hs;
  logic                  widx;
  logic                  fault_state;
  logic                  fault_head;

  bitwise_TMR_voter_fail #(
    .DataWidth(StateWidth)
  ) i_state_voter (
    .a_i             (state_a_i),
    .b_i             (state_b_i),
    .c_i             (state_c_i),
    .majority_o      (state_vote),
    .fault_detected_o(fault_state)
  );

  TMR_voter_fail i_head_voter (
    .a_i             (head_a_i),
    .b_i             (head_b_i),
    .c_i             (head_c_i),
    .majority_o      (head_v),
    .fault_detected_o(fault_head)
  );

  // Next-state logic runs on the voted copy so a lone upset is overwritten next edge.
  always_comb begin
    state_v    = egress_state_e'(state_vote);
    state_d    = state_v;
    head_d     = head_v;
    valid_o    = (state_v != EMPTY);
    hs         = valid_o & ready_i;
    fifo_pop_o = ~fifo_empty_i & (state_v != TWO) & ~flush_i & ~rst_i;
    widx       = head_v ^ (state_v == ONE);
    we_o       = egress_we(fifo_pop_o, widx);

    if (flush_i) begin
      state_d = EMPTY;
      head_d  = 1'b0;
    end else begin
      case (state_v)
        EMPTY: if (fifo_pop_o) state_d = ONE;
        ONE: begin
          if (fifo_pop_o && !hs) begin
            state_d = TWO;
          end else if (!fifo_pop_o && hs) begin
            state_d = EMPTY;
          end
        end
        TWO:     if (hs) state_d = ONE;
        default: state_d = EMPTY;
      endcase
      if (hs) begin
        head_d = ~head_v;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  assign state_o = state_q;
  assign head_o  = head_q;
  assign fault_o = fault_state | fault_head;

endmodule

// File: rtl/rel_fifo_egress.sv
// Two-entry TMR-controlled output buffer between a rel_fifo and its consumer.
// Control is triplicated; the ECC-protected data storage is a single copy.
module rel_fifo_egress
  import rel_fifo_pkg::*;
#(
  parameter int unsigned  DataWidth = 39,
  parameter bit           TmrStatus = 1'b1,
  localparam int unsigned HsWidth   = TmrStatus ? 32'd3 : 32'd1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [HsWidth-1:0]   flush_i,
  input  logic [HsWidth-1:0]   fifo_empty_i,
  input  logic [DataWidth-1:0] fifo_data_i,
  output logic [HsWidth-1:0]   fifo_pop_o,
  output logic [HsWidth-1:0]   valid_o,
  input  logic [HsWidth-1:0]   ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 fault_o
);

  logic [2:0]             flush_r;
  logic [2:0]             empty_r;
  logic [2:0]             ready_r;
  logic [2:0]             pop_r;
  logic [2:0]             valid_r;
  logic [2:0]             head_r;
  logic [2:0]             fault_r;
  egress_state_e          state_0;
  egress_state_e          state_1;
  egress_state_e          state_2;
  logic [EgressDepth-1:0] we_0;
  logic [EgressDepth-1:0] we_1;
  logic [EgressDepth-1:0] we_2;
  logic [EgressDepth-1:0] we_v;
  logic                   head_v;
  logic                   fault_we;
  logic                   fault_head;
  logic                   fault_out;
  logic [DataWidth-1:0]   entry_d [EgressDepth];
  logic [DataWidth-1:0]   entry_q [EgressDepth];

  // Triplicated ports map one lane per replica; single ports fan out and vote back.
  if (TmrStatus) begin : gen_tmr_ports
    assign flush_r    = flush_i;
    assign empty_r    = fifo_empty_i;
    assign ready_r    = ready_i;
    assign fifo_pop_o = pop_r;
    assign valid_o    = valid_r;
    assign fault_out  = 1'b0;
  end else begin : gen_single_ports
    logic fault_pop;
    logic fault_valid;

    assign flush_r = {3{flush_i}};
    assign empty_r = {3{fifo_empty_i}};
    assign ready_r = {3{ready_i}};

    TMR_voter_fail i_pop_voter (
      .a_i             (pop_r[0]),
      .b_i             (pop_r[1]),
      .c_i             (pop_r[2]),
      .majority_o      (fifo_pop_o),
      .fault_detected_o(fault_pop)
    );

    TMR_voter_fail i_valid_voter (
      .a_i             (valid_r[0]),
      .b_i             (valid_r[1]),
      .c_i             (valid_r[2]),
      .majority_o      (valid_o),
      .fault_detected_o(fault_valid)
    );

    assign fault_out = fault_pop | fault_valid;
  end

  (* no_ungroup *) (* no_boundary_optimization *)
  rel_fifo_egress_tmr_part i_tmr_part_0 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_r[0]),
    .fifo_empty_i(empty_r[0]),
    .ready_i     (ready_r[0]),
    .state_a_i   (state_0),
    .state_b_i   (state_1),
    .state_c_i   (state_2),
    .head_a_i    (head_r[0]),
    .head_b_i    (head_r[1]),
    .head_c_i    (head_r[2]),
    .state_o     (state_0),
    .head_o      (head_r[0]),
    .we_o        (we_0),
    .fifo_pop_o  (pop_r[0]),
    .valid_o     (valid_r[0]),
    .fault_o     (fault_r[0])
  );

  (* no_ungroup *) (* no_boundary_optimization *)
  rel_fifo_egress_tmr_part i_tmr_part_1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_r[1]),
    .fifo_empty_i(empty_r[1]),
    .ready_i     (ready_r[1]),
    .state_a_i   (state_0),
    .state_b_i   (state_1),
    .state_c_i   (state_2),
    .head_a_i    (head_r[0]),
    .head_b_i    (head_r[1]),
    .head_c_i    (head_r[2]),
    .state_o     (state_1),
    .head_o      (head_r[1]),
    .we_o        (we_1),
    .fifo_pop_o  (pop_r[1]),
    .valid_o     (valid_r[1]),
    .fault_o     (fault_r[1])
  );

  (* no_ungroup *) (* no_boundary_optimization *)
  rel_fifo_egress_tmr_part i_tmr_part_2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_r[2]),
    .fifo_empty_i(empty_r[2]),
    .ready_i     (ready_r[2]),
    .state_a_i   (state_0),
    .state_b_i   (state_1),
    .state_c_i   (state_2),
    .head_a_i    (head_r[0]),
    .head_b_i    (head_r[1]),
    .head_c_i    (head_r[2]),
    .state_o     (state_2),
    .head_o      (head_r[2]),
    .we_o        (we_2),
    .fifo_pop_o  (pop_r[2]),
    .valid_o     (valid_r[2]),
    .fault_o     (fault_r[2])
  );

  bitwise_TMR_voter_fail #(
    .DataWidth(EgressDepth)
  ) i_we_voter (
    .a_i             (we_0),
    .b_i             (we_1),
    .c_i             (we_2),
    .majority_o      (we_v),
    .fault_detected_o(fault_we)
  );

  TMR_voter_fail i_read_head_voter (
    .a_i             (head_r[0]),
    .b_i             (head_r[1]),
    .c_i             (head_r[2]),
    .majority_o      (head_v),
    .fault_detected_o(fault_head)
  );

  always_comb begin
    for (int unsigned i = 0; i < EgressDepth; i++) begin
      entry_d[i] = we_v[i] ? fifo_data_i : entry_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < EgressDepth; i++) begin
      if (rst_i) begin
        entry_q[i] <= '0;
      end else begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign data_o  = entry_q[head_v];
  assign fault_o = (|fault_r) | fault_we | fault_head | fault_out;

endmodule

// File: tb/tb_rel_fifo_egress.sv
// Directed and random checks of rel_fifo_egress (both port flavours) against a queue model.
module tb_rel_fifo_egress;
  import rel_fifo_pkg::*;

  localparam int unsigned DW = 39;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          empty;
  logic          ready;
  logic [DW-1:0] din;

  logic [2:0]    pop3;
  logic [2:0]    valid3;
  logic [DW-1:0] data3;
  logic          fault3;
  logic          pop1;
  logic          valid1;
  logic [DW-1:0] data1;
  logic          fault1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit inj      = 1'b0;

  logic [DW-1:0] mq[$];

  always #5 clk = ~clk;

  rel_fifo_egress #(.DataWidth(DW), .TmrStatus(1'b1)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i({3{flush}}), .fifo_empty_i({3{empty}}),
    .fifo_data_i(din), .fifo_pop_o(pop3), .valid_o(valid3), .ready_i({3{ready}}),
    .data_o(data3), .fault_o(fault3)
  );

  rel_fifo_egress #(.DataWidth(DW), .TmrStatus(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .fifo_empty_i(empty),
    .fifo_data_i(din), .fifo_pop_o(pop1), .valid_o(valid1), .ready_i(ready),
    .data_o(data1), .fault_o(fault1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit e, input bit rd, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    rst   = r;
    flush = f;
    empty = e;
    ready = rd;
    din   = d;
  endtask

  // Buffer model: a queue of at most two words, popped on handshake, filled on pop.
  always @(posedge clk) begin : model
    bit v;
    bit p;
    if (rst || flush) begin
      mq.delete();
    end else begin
      v = (mq.size() != 0);
      p = !empty && (mq.size() < 2);
      if (v && ready) void'(mq.pop_front());
      if (p) mq.push_back(din);
    end
  end

  always @(negedge clk) begin : monitor
    bit exp_v;
    bit exp_p;
    if (mon_en) begin
      exp_v = (mq.size() != 0);
      exp_p = !rst && !flush && !empty && (mq.size() < 2);
      check("valid3", 64'(valid3), 64'({3{exp_v}}));
      check("pop3",   64'(pop3),   64'({3{exp_p}}));
      check("valid1", 64'(valid1), 64'(exp_v));
      check("pop1",   64'(pop1),   64'(exp_p));
      check("fault1", 64'(fault1), 64'd0);
      if (!inj) check("fault3", 64'(fault3), 64'd0);
      if (exp_v) begin
        check("data3", 64'(data3), 64'(mq[0]));
        check("data1", 64'(data1), 64'(mq[0]));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; empty = 1'b1; ready = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_data3", 64'(data3), 64'd0);
    check("rst_data1", 64'(data1), 64'd0);
    check("rst_valid3", 64'(valid3), 64'd0);

    // Streaming at one word per cycle
    step(0, 0, 0, 1, DW'('h11)); @(negedge clk); check("s_pop", 64'(pop3), 64'h7);
    step(0, 0, 0, 1, DW'('h22)); @(negedge clk); check("s_d11", 64'(data3), 64'h11);
    step(0, 0, 0, 1, DW'('h33)); @(negedge clk); check("s_d22", 64'(data3), 64'h22);
    step(0, 0, 1, 1, '0);        @(negedge clk); check("s_d33", 64'(data3), 64'h33);
    step(0, 0, 1, 1, '0);        @(negedge clk); check("s_idle", 64'(valid3), 64'd0);

    // Backpressure fills both entries, then drains in order
    step(0, 0, 0, 0, DW'('h44)); @(negedge clk); check("b_pop0", 64'(pop3), 64'h7);
    step(0, 0, 0, 0, DW'('h55)); @(negedge clk); check("b_d44a", 64'(data3), 64'h44);
    step(0, 0, 0, 0, DW'('h66)); @(negedge clk); check("b_full_pop", 64'(pop3), 64'd0);
    check("b_d44b", 64'(data3), 64'h44);
    step(0, 0, 0, 0, DW'('h66)); @(negedge clk); check("b_hold", 64'(data3), 64'h44);
    step(0, 0, 0, 1, DW'('h66)); @(negedge clk); check("b_d44c", 64'(data3), 64'h44);
    step(0, 0, 0, 1, DW'('h66)); @(negedge clk); check("b_d55", 64'(data3), 64'h55);
    step(0, 0, 1, 1, '0);        @(negedge clk); check("b_d66", 64'(data3), 64'h66);
    step(0, 0, 1, 1, '0);        @(negedge clk); check("b_empty", 64'(valid3), 64'd0);

    // Flush from TWO with head parked at entry 1
    step(0, 0, 0, 1, DW'('h70));
    step(0, 0, 0, 1, DW'('h71));
    step(0, 0, 0, 0, DW'('h72));
    step(0, 0, 0, 0, DW'('h73)); @(negedge clk); check("f_full", 64'(valid3), 64'h7);
    step(0, 1, 0, 0, DW'('h73)); @(negedge clk); check("f_pop", 64'(pop3), 64'd0);
    check("f_pop1", 64'(pop1), 64'd0);
    step(0, 0, 1, 0, '0);        @(negedge clk); check("f_valid", 64'(valid3), 64'd0);
    step(0, 0, 0, 1, DW'('h77));
    step(0, 0, 1, 1, '0);        @(negedge clk); check("f_d77", 64'(data3), 64'h77);
    check("f_entry0", 64'(dut3.entry_q[0]), 64'h77);

    // Reset while full discards both words
    step(0, 0, 0, 0, DW'('h81));
    step(0, 0, 0, 0, DW'('h82));
    step(0, 0, 1, 0, '0);        @(negedge clk); check("r_d81", 64'(data3), 64'h81);
    step(1, 0, 1, 0, '0);
    step(0, 0, 1, 0, '0);        @(negedge clk); check("r_valid", 64'(valid3), 64'd0);
    check("r_data3", 64'(data3), 64'd0);
    check("r_data1", 64'(data1), 64'd0);

    // Single-replica state upset in ONE
    step(0, 0, 0, 0, DW'('h91));
    step(0, 0, 1, 0, '0);
    inj = 1'b1;
    @(negedge clk);
    force dut3.i_tmr_part_1.state_q = TWO;
    #2;
    check("i_fault", 64'(fault3), 64'd1);
    check("i_valid", 64'(valid3), 64'h7);
    check("i_data", 64'(data3), 64'h91);
    #2;
    release dut3.i_tmr_part_1.state_q;
    @(negedge clk);
    check("i_fault_clr", 64'(fault3), 64'd0);
    check("i_resync", 64'(dut3.i_tmr_part_1.state_q), 64'(ONE));
    inj = 1'b0;
    step(0, 0, 1, 1, '0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      step(r == 0, (r >= 1) && (r < 5), $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, DW'({$urandom(), $urandom()}));
    end
    step(1, 0, 1, 0, '0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
